// File: rtl/countdown_pkg.sv
// countdown_pkg: state encoding, BCD widths and time constants shared by the
// countdown timer controller and its interface.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam int BCD_W       = 4;
  localparam int DIGITS_W    = 4 * BCD_W;
  localparam int VALUE_W     = 8;
  localparam int SEC_PER_MIN = 60;

  // Split a binary value in 0..99 into {tens, units} BCD nibbles.
  function automatic logic [2*BCD_W-1:0] to_bcd2(input logic [VALUE_W-1:0] bin);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
    tens  = BCD_W'(bin / 8'd10);
    units = BCD_W'(bin % 8'd10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// countdown_ctrl_if: control pulses, preset and display/buzzer outputs of the
// countdown controller. The controller uses the slave modport.
interface countdown_ctrl_if;
  import countdown_pkg::*;

  logic                start;
  logic                pause;
  logic                clear;
  logic [VALUE_W-1:0]  preset;
  logic [DIGITS_W-1:0] digits;
  logic                buzz;
  logic [1:0]          state_o;
  logic                done;
  logic                blank;

  modport master (
    output start, pause, clear, preset,
    input  digits, buzz, state_o, done, blank
  );

  modport slave (
    input  start, pause, clear, preset,
    output digits, buzz, state_o, done, blank
  );

endinterface

// File: rtl/countdown_ctrl_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle tick every DIV enabled cycles.
// The count holds while en is low and restarts from 0 on clr.
module tick_prescaler #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      if (w_at_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign tick = en && w_at_last;

endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: IDLE/RUN/PAUSE/ALARM sequencer with mm:ss BCD display and buzzer.
// Define COUNTDOWN_BLINK_EN to blink the display (blank) at 1 Hz while paused.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_DIV    = 25_000_000,
  parameter int ALARM_BEEPS = 3
) (
  input logic             clk,
  input logic             reset,
  countdown_ctrl_if.slave bus
);

  localparam int               TGL_W    = $clog2(2 * ALARM_BEEPS);
  localparam logic [TGL_W-1:0] LAST_TGL = TGL_W'(2 * ALARM_BEEPS - 1);

  state_t              r_state;
  logic [VALUE_W-1:0]  r_value;
  logic [TGL_W-1:0]    r_tgl_cnt;
  logic                r_buzz;
  logic                r_done;
  logic [DIGITS_W-1:0] r_digits;

  logic                w_tick;
  logic                w_presc_en;
  logic                w_presc_clr;
  logic [VALUE_W-1:0]  w_min;
  logic [VALUE_W-1:0]  w_sec;
  logic [DIGITS_W-1:0] w_digits;

  // The prescaler restarts on clear and on an accepted start from IDLE; a
  // resume from PAUSE keeps the held count so the partial second is not lost.
  assign w_presc_en  = (r_state == ST_RUN) || (r_state == ST_ALARM);
  assign w_presc_clr = bus.clear ||
                       ((r_state == ST_IDLE) && bus.start && (r_value != '0));

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (w_presc_en),
    .clr   (w_presc_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_value   <= '0;
      r_tgl_cnt <= '0;
      r_buzz    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.clear) begin
        r_state   <= ST_IDLE;
        r_value   <= bus.preset;
        r_tgl_cnt <= '0;
        r_buzz    <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start && (r_value != '0)) begin
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            // The final tick beats a coincident pause.
            if (w_tick && (r_value != '0)) begin
              r_value <= r_value - 1'b1;
              if (r_value == VALUE_W'(1)) begin
                r_state   <= ST_ALARM;
                r_tgl_cnt <= '0;
              end else if (bus.pause) begin
                r_state <= ST_PAUSE;
              end
            end else if (bus.pause) begin
              r_state <= ST_PAUSE;
            end
          end
          ST_PAUSE: begin
            if (bus.start) begin
              r_state <= ST_RUN;
            end
          end
          ST_ALARM: begin
            if (bus.start) begin
              r_state   <= ST_IDLE;
              r_tgl_cnt <= '0;
              r_buzz    <= 1'b1;
              r_done    <= 1'b1;
            end else if (w_tick) begin
              if (r_tgl_cnt == LAST_TGL) begin
                r_state   <= ST_IDLE;
                r_tgl_cnt <= '0;
                r_buzz    <= 1'b1;
                r_done    <= 1'b1;
              end else begin
                r_tgl_cnt <= r_tgl_cnt + 1'b1;
                r_buzz    <= ~r_buzz;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Binary seconds to mm:ss; minutes never exceed 4 for an 8-bit value.
  always_comb begin
    w_min    = r_value / VALUE_W'(SEC_PER_MIN);
    w_sec    = r_value % VALUE_W'(SEC_PER_MIN);
    w_digits = {to_bcd2(w_min), to_bcd2(w_sec)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digits <= '0;
    end else begin
      r_digits <= w_digits;
    end
  end

  assign bus.digits  = r_digits;
  assign bus.buzz    = r_buzz;
  assign bus.state_o = r_state;
  assign bus.done    = r_done;

`ifdef COUNTDOWN_BLINK_EN
  localparam int                HALF   = TICK_DIV / 2;
  localparam int                HALF_W = $clog2(HALF + 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);

  logic [HALF_W-1:0] r_half_cnt;
  logic              r_blank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_half_cnt <= '0;
      r_blank    <= 1'b0;
    end else begin
      if (r_half_cnt == HALF_LAST) begin
        r_half_cnt <= '0;
      end else begin
        r_half_cnt <= r_half_cnt + 1'b1;
      end
      if (r_state != ST_PAUSE) begin
        r_blank <= 1'b0;
      end else if (r_half_cnt == HALF_LAST) begin
        r_blank <= ~r_blank;
      end
    end
  end

  assign bus.blank = r_blank;
`else
  assign bus.blank = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: scenario tasks for countdown_ctrl with TICK_DIV=4, ALARM_BEEPS=2;
// expected display/buzzer events are queued at stimulus time and checked on output.
`timescale 1ns/1ps
module tb_countdown_ctrl;

  localparam int TD = 4;
  localparam int NB = 2;

  localparam logic [7:0]  PRE_TAB [5] = '{8'd125, 8'd255, 8'd60, 8'd59, 8'd0};
  localparam logic [15:0] BCD_TAB [5] = '{16'h0205, 16'h0415, 16'h0100, 16'h0059, 16'h0000};

  typedef struct {
    logic [15:0] val;
    int          at;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   done_cnt = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  exp_t dq[$];
  exp_t bq[$];

  countdown_ctrl_if bus ();

  countdown_ctrl #(
    .TICK_DIV    (TD),
    .ALARM_BEEPS (NB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, n_tests=%0d", n_tests);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic s, input logic p, input logic c);
    bus.start = s;
    bus.pause = p;
    bus.clear = c;
    step(1);
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic push_exp(input bit to_buzz, input logic [15:0] val, input int at);
    exp_t e;
    e.val = val;
    e.at  = at;
    if (to_buzz) bq.push_back(e);
    else         dq.push_back(e);
  endtask

  task automatic wait_digits_change(input int limit, output bit ok);
    logic [15:0] prev;
    prev = bus.digits;
    ok   = 1'b0;
    for (int k = 0; k < limit; k++) begin
      step(1);
      if (bus.digits !== prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_buzz_change(input int limit, output bit ok);
    logic prev;
    prev = bus.buzz;
    ok   = 1'b0;
    for (int k = 0; k < limit; k++) begin
      step(1);
      if (bus.buzz !== prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    n_tests++; if (bus.digits !== 16'h0000) begin n_fail++; $display("FAIL reset_digits: got %h want 0000", bus.digits); end
    n_tests++; if (bus.buzz !== 1'b1) begin n_fail++; $display("FAIL reset_buzz: got %b want 1", bus.buzz); end
    n_tests++; if (bus.state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.state_o); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_tests++; if (bus.blank !== 1'b0) begin n_fail++; $display("FAIL reset_blank: got %b want 0", bus.blank); end
    #2 reset = 1'b0;
    step(2);
    n_tests++; if (bus.state_o !== 2'd0 || bus.digits !== 16'h0000) begin n_fail++; $display("FAIL reset_release: state %0d digits %h want 0 / 0000", bus.state_o, bus.digits); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_countdown_alarm();
    exp_t e;
    bit   ok;
    int   e0;
    bus.preset = 8'd3;
    pulse(0, 0, 1);
    step(1);
    n_tests++; if (bus.digits !== 16'h0003) begin n_fail++; $display("FAIL cd_load: got %h want 0003", bus.digits); end
    pulse(1, 0, 0);
    e0 = cyc;
    done_cnt = 0;
    n_tests++; if (bus.state_o !== 2'd1) begin n_fail++; $display("FAIL cd_run: got %0d want 1", bus.state_o); end
    push_exp(0, 16'h0002, e0 + 5);
    push_exp(0, 16'h0001, e0 + 9);
    push_exp(0, 16'h0000, e0 + 13);
    while (dq.size() > 0) begin
      e = dq.pop_front();
      wait_digits_change(8, ok);
      n_tests++;
      if (!ok || bus.digits !== e.val || cyc != e.at) begin
        n_fail++;
        $display("FAIL cd_digits: got %h at +%0d want %h at +%0d (changed=%0b)", bus.digits, cyc - e0, e.val, e.at - e0, ok);
      end
      $display("[TB] countdown digits %h at +%0d", bus.digits, cyc - e0);
    end
    n_tests++; if (bus.state_o !== 2'd3) begin n_fail++; $display("FAIL cd_alarm: got %0d want 3", bus.state_o); end
    push_exp(1, 16'h0000, e0 + 16);
    push_exp(1, 16'h0001, e0 + 20);
    push_exp(1, 16'h0000, e0 + 24);
    push_exp(1, 16'h0001, e0 + 28);
    while (bq.size() > 0) begin
      e = bq.pop_front();
      wait_buzz_change(8, ok);
      n_tests++;
      if (!ok || bus.buzz !== e.val[0] || cyc != e.at) begin
        n_fail++;
        $display("FAIL cd_buzz: got %b at +%0d want %b at +%0d (changed=%0b)", bus.buzz, cyc - e0, e.val[0], e.at - e0, ok);
      end
      $display("[TB] alarm buzz %b at +%0d", bus.buzz, cyc - e0);
    end
    n_tests++; if (bus.done !== 1'b1 || bus.state_o !== 2'd0) begin n_fail++; $display("FAIL cd_finish: done %b state %0d want 1 / 0", bus.done, bus.state_o); end
    step(3);
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL cd_done_count: got %0d want 1", done_cnt); end
    n_tests++; if (bus.buzz !== 1'b1 || bus.digits !== 16'h0000) begin n_fail++; $display("FAIL cd_idle: buzz %b digits %h want 1 / 0000", bus.buzz, bus.digits); end
  endtask

  task automatic test_bcd_conversion();
    exp_t e;
    bit   ok;
    int   e0;
    for (int i = 0; i < 5; i++) begin
      bus.preset = PRE_TAB[i];
      pulse(0, 0, 1);
      push_exp(0, BCD_TAB[i], cyc + 1);
      step(1);
      e = dq.pop_front();
      n_tests++;
      if (bus.digits !== e.val || cyc != e.at) begin
        n_fail++;
        $display("FAIL bcd_preset_%0d: got %h want %h", PRE_TAB[i], bus.digits, e.val);
      end
      $display("[TB] preset %0d -> digits %h", PRE_TAB[i], bus.digits);
    end
    bus.preset = 8'd125;
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    e0 = cyc;
    push_exp(0, 16'h0204, e0 + 5);
    e = dq.pop_front();
    wait_digits_change(8, ok);
    n_tests++;
    if (!ok || bus.digits !== e.val || cyc != e.at) begin
      n_fail++;
      $display("FAIL bcd_tick: got %h at +%0d want %h at +%0d", bus.digits, cyc - e0, e.val, e.at - e0);
    end
    pulse(0, 0, 1);
  endtask

  task automatic test_pause_resume();
    exp_t e;
    bit   ok;
    int   r;
    bus.preset = 8'd5;
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    step(1);
    pulse(0, 1, 0);
    n_tests++; if (bus.state_o !== 2'd2) begin n_fail++; $display("FAIL pause_enter: got %0d want 2", bus.state_o); end
    step(10);
    pulse(0, 1, 0);
    step(10);
    n_tests++; if (bus.digits !== 16'h0005 || bus.state_o !== 2'd2) begin n_fail++; $display("FAIL pause_hold: digits %h state %0d want 0005 / 2", bus.digits, bus.state_o); end
    pulse(1, 1, 0);
    r = cyc;
    n_tests++; if (bus.state_o !== 2'd1) begin n_fail++; $display("FAIL pause_resume: got %0d want 1", bus.state_o); end
    push_exp(0, 16'h0004, r + 3);
    e = dq.pop_front();
    wait_digits_change(8, ok);
    n_tests++;
    if (!ok || bus.digits !== e.val || cyc != e.at) begin
      n_fail++;
      $display("FAIL pause_next_tick: got %h at +%0d want %h at +%0d", bus.digits, cyc - r, e.val, e.at - r);
    end
    $display("[TB] resume tick digits %h at +%0d", bus.digits, cyc - r);
    pulse(0, 0, 1);
  endtask

  task automatic test_pause_final_tick();
    bus.preset = 8'd1;
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    done_cnt = 0;
    step(3);
    pulse(0, 1, 0);
    n_tests++; if (bus.state_o !== 2'd3) begin n_fail++; $display("FAIL pause_final: got %0d want 3", bus.state_o); end
    step(1);
    n_tests++; if (bus.digits !== 16'h0000) begin n_fail++; $display("FAIL pause_final_val: got %h want 0000", bus.digits); end
    pulse(0, 0, 1);
    step(2);
    n_tests++; if (bus.state_o !== 2'd0 || bus.buzz !== 1'b1 || done_cnt != 0) begin n_fail++; $display("FAIL alarm_clear: state %0d buzz %b done_cnt %0d want 0 / 1 / 0", bus.state_o, bus.buzz, done_cnt); end
  endtask

  task automatic test_start_zero();
    bit bad_state;
    bit bad_buzz;
    bad_state = 1'b0;
    bad_buzz  = 1'b0;
    bus.preset = 8'd0;
    pulse(0, 0, 1);
    done_cnt = 0;
    pulse(1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      if (bus.state_o !== 2'd0) bad_state = 1'b1;
      if (bus.buzz !== 1'b1) bad_buzz = 1'b1;
      step(1);
    end
    n_tests++; if (bad_state) begin n_fail++; $display("FAIL zero_state: state left IDLE, want 0"); end
    n_tests++; if (bad_buzz) begin n_fail++; $display("FAIL zero_buzz: buzz went low, want 1"); end
    n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL zero_done: got %0d pulses want 0", done_cnt); end
  endtask

  task automatic test_alarm_ack();
    bit ok;
    bus.preset = 8'd1;
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    wait_buzz_change(12, ok);
    n_tests++; if (!ok || bus.buzz !== 1'b0 || bus.state_o !== 2'd3) begin n_fail++; $display("FAIL ack_toggle: buzz %b state %0d want 0 / 3 (changed=%0b)", bus.buzz, bus.state_o, ok); end
    done_cnt = 0;
    pulse(1, 0, 0);
    n_tests++; if (bus.state_o !== 2'd0 || bus.buzz !== 1'b1 || bus.done !== 1'b1) begin n_fail++; $display("FAIL ack_edge: state %0d buzz %b done %b want 0 / 1 / 1", bus.state_o, bus.buzz, bus.done); end
    step(1);
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL ack_done_width: got %b want 0", bus.done); end
    step(8);
    n_tests++; if (done_cnt != 1 || bus.buzz !== 1'b1) begin n_fail++; $display("FAIL ack_after: done_cnt %0d buzz %b want 1 / 1", done_cnt, bus.buzz); end
  endtask

  task automatic test_clear_final_tick_and_reset();
    int e0;
    bus.preset = 8'd2;
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    e0 = cyc;
    done_cnt = 0;
    bus.preset = 8'd7;
    while (cyc < e0 + 7) step(1);
    pulse(0, 0, 1);
    n_tests++; if (bus.state_o !== 2'd0) begin n_fail++; $display("FAIL clr_final_state: got %0d want 0", bus.state_o); end
    step(1);
    n_tests++; if (bus.digits !== 16'h0007 || bus.buzz !== 1'b1 || done_cnt != 0) begin n_fail++; $display("FAIL clr_final_val: digits %h buzz %b done_cnt %0d want 0007 / 1 / 0", bus.digits, bus.buzz, done_cnt); end
    pulse(1, 0, 0);
    step(5);
    n_tests++; if (bus.digits !== 16'h0006 || bus.state_o !== 2'd1) begin n_fail++; $display("FAIL mid_run: digits %h state %0d want 0006 / 1", bus.digits, bus.state_o); end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (bus.digits !== 16'h0000 || bus.buzz !== 1'b1 || bus.state_o !== 2'd0 || bus.done !== 1'b0 || bus.blank !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: digits %h buzz %b state %0d done %b blank %b want 0000 1 0 0 0", bus.digits, bus.buzz, bus.state_o, bus.done, bus.blank);
    end
    step(2);
    reset = 1'b0;
    step(2);
    pulse(1, 0, 0);
    step(1);
    n_tests++; if (bus.state_o !== 2'd0 || bus.digits !== 16'h0000) begin n_fail++; $display("FAIL post_reset: state %0d digits %h want 0 / 0000", bus.state_o, bus.digits); end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.pause  = 1'b0;
    bus.clear  = 1'b0;
    bus.preset = 8'd0;
    test_reset();
    test_countdown_alarm();
    test_bcd_conversion();
    test_pause_resume();
    test_pause_final_tick();
    test_start_zero();
    test_alarm_ack();
    test_clear_final_tick_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for the seconds-countdown timer datapath. It takes start, pause and clear pulses plus an 8-bit preset in seconds. It runs an IDLE/RUN/PAUSE/ALARM state machine over a 1 s tick prescaler and produces the remaining time as four BCD digits (mm:ss) for the seven-segment scan driver. It also drives the buzzer pattern when the count expires.

## Interface
- TICK_DIV, 25_000_000: clk cycles per 1 s tick; must be ≥ 2.
- ALARM_BEEPS, 3: number of buzzer on/off pairs in ALARM; must be ≥ 1.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse, already synchronised: start, resume, or acknowledge the alarm.
- pause  in  1  one-cycle pulse: pause while in RUN.
- clear  in  1  one-cycle pulse: abort and reload the preset.
- preset  in  8  countdown start value in seconds, 0–255.
- digits  out  16  BCD time: [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units.
- buzz  out  1  buzzer drive, active-low; idles at 1.
- state_o  out  2  current state: 0 IDLE, 1 RUN, 2 PAUSE, 3 ALARM.
- done  out  1  one-cycle pulse when ALARM completes or is acknowledged.
- blank  out  1  display blank request (see Configuration).

## Operation
- Internal value is 8-bit seconds. On reset it is cleared to 0 and preset is not sampled.
- clear has priority over start and pause in every state. On clear:
  - state → IDLE, value ← preset, prescaler ← 0, buzz ← 1, alarm counter ← 0.
- IDLE:
  - start with value ≠ 0 → RUN, prescaler ← 0.
  - start with value = 0 is ignored.
  - pause is ignored.
- RUN:
  - On each tick, value decrements by 1.
  - The tick that takes value from 1 to 0 also moves to ALARM on the same edge.
  - pause → PAUSE; the prescaler count is held, not cleared.
  - start is ignored.
- PAUSE:
  - start → RUN; the prescaler resumes from its held count.
  - pause is ignored.
- ALARM:
  - On each tick, buzz toggles and the toggle counter increments.
  - After 2·ALARM_BEEPS toggles: buzz = 1, done pulses, state → IDLE, value stays 0.
  - start (acknowledge) → IDLE at once, buzz ← 1, done pulses.
- Display conversion:
  - min = value / 60, sec = value % 60.
  - Each is split into tens and units; min tens is always 0 for 8-bit input.
  - Nibbles never exceed 9.
- Value never wraps. Decrement is only applied when value ≠ 0.

## Timing
- Reset values: digits = 16'h0000, buzz = 1, state_o = 0, done = 0, blank = 0, prescaler = 0.
- The prescaler counts only in RUN and ALARM. tick is asserted for one cycle when the count = TICK_DIV−1, and the count then wraps to 0.
- The first tick after start from IDLE falls TICK_DIV cycles after the start edge.
- digits is registered and reflects value one cycle after value changes.
- state_o and buzz change on the same edge as the triggering pulse or tick. done is high for exactly one cycle.
- Simultaneous events:
  - clear with any other pulse: clear wins.
  - pause coinciding with the final tick in RUN: the tick wins, state → ALARM, value = 0.
  - start and pause in the same cycle in PAUSE: start wins.
- Asynchronous reset mid-RUN or mid-ALARM aborts immediately to the reset values.

## Configuration
- COUNTDOWN_BLINK_EN defined:
  - In PAUSE, blank toggles on every TICK_DIV/2 cycles of a free-running half-period counter, giving a 1 Hz blink.
  - blank returns to 0 on leaving PAUSE.
- Undefined: blank is constant 0 and the half-period counter is not built.

## Structure
- Package countdown_pkg holds:
  - the state encoding (IDLE/RUN/PAUSE/ALARM, 2 bits);
  - the BCD nibble width;
  - the SEC_PER_MIN = 60 constant.
- Sub-module tick_prescaler: parameter DIV; inputs clk, reset, en, clr; output tick.
- Binary to mm:ss BCD conversion stays in this module as registered logic.

## Test plan
All scenarios use TICK_DIV = 4 and ALARM_BEEPS = 2.
- Preset 3, clear, start → RUN; digits 0003 → 0002 → 0001 → 0000 at 4-cycle spacing; ALARM on the tick that reaches 0; buzz toggles four times, 4 cycles apart; done pulses once; state_o = 0; buzz = 1.
- Preset 125, clear → digits = 16'h0205; start, one tick → 16'h0204.
- Preset 5, start, pause after 2 cycles, wait 20 cycles → value unchanged; start → next tick 2 cycles later.
- Start with value 0 in IDLE → state stays IDLE, no done, buzz stays 1.
- Start during ALARM after the first toggle → same-edge IDLE, buzz = 1, done pulses once.
- Clear concurrent with the final RUN tick → IDLE, value = preset, no ALARM. Then reset asserted mid-RUN → all outputs at reset values.
